// File: rtl/bcd_to_binary_seq_if.sv
// Handshake/data bundle for the sequential packed-BCD to binary converter.
// The master drives the start strobe and BCD word; the slave returns the result.
interface bcd_to_binary_seq_if #(
    parameter int unsigned binaryNumberWidth = 32,
    parameter int unsigned numberOfDigits    = 6
);
    logic                               load;
    logic [numberOfDigits-1:0][3:0]     BinaryDecimal;
    logic [binaryNumberWidth-1:0]       binaryNumber;
    logic                               enaOut;
    logic                               busy;
    logic                               error;
    logic                               overflow;

    modport master (
        output load,
        output BinaryDecimal,
        input  binaryNumber,
        input  enaOut,
        input  busy,
        input  error,
        input  overflow
    );

    modport slave (
        input  load,
        input  BinaryDecimal,
        output binaryNumber,
        output enaOut,
        output busy,
        output error,
        output overflow
    );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter. Folds one BCD digit per clock,
// most-significant first (acc = acc*10 + digit), then presents a registered
// result with a one-cycle enaOut strobe plus error/overflow status.
module bcd_to_binary_seq #(
    parameter int unsigned binaryNumberWidth = 32,
    parameter int unsigned numberOfDigits    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_to_binary_seq_if.slave    bus
);
    localparam int unsigned ACC_W = 4 * numberOfDigits;
    localparam int unsigned CNT_W = (numberOfDigits > 1) ? $clog2(numberOfDigits) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(numberOfDigits - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t                        state_q, state_d;
    logic [ACC_W-1:0]              sr_q, sr_d;
    logic [ACC_W-1:0]              acc_q, acc_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          invalid_q, invalid_d;
    logic [binaryNumberWidth-1:0]  bin_q, bin_d;
    logic                          ena_q, ena_d;
    logic                          err_q, err_d;
    logic                          ovf_q, ovf_d;

    logic [3:0]                    digit;
    logic [binaryNumberWidth-1:0]  result_w;
    logic                          ovf_w;

    // Result truncation and overflow detection; overflow cannot occur when
    // the output is at least as wide as the internal accumulator.
    if (binaryNumberWidth >= ACC_W) begin : g_wide
        assign result_w = binaryNumberWidth'(acc_q);
        assign ovf_w    = 1'b0;
    end else begin : g_narrow
        assign result_w = acc_q[binaryNumberWidth-1:0];
        assign ovf_w    = |acc_q[ACC_W-1:binaryNumberWidth];
    end

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            invalid_q <= 1'b0;
            bin_q     <= '0;
            ena_q     <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            invalid_q <= invalid_d;
            bin_q     <= bin_d;
            ena_q     <= ena_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state and datapath logic: capture in IDLE, fold digits in CONV,
    // publish the result in DONE.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        invalid_d = invalid_q;
        bin_d     = bin_q;
        ena_d     = 1'b0;
        err_d     = err_q;
        ovf_d     = ovf_q;
        digit     = sr_q[ACC_W-1 -: 4];

        unique case (state_q)
            IDLE: begin
                if (bus.load) begin
                    sr_d      = bus.BinaryDecimal;
                    acc_d     = '0;
                    cnt_d     = '0;
                    invalid_d = 1'b0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                acc_d = (acc_q << 3) + (acc_q << 1) + ACC_W'(digit);
                sr_d  = sr_q << 4;
                if (digit > 4'd9) begin
                    invalid_d = 1'b1;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ena_d = 1'b1;
                if (invalid_q) begin
                    bin_d = '0;
                    err_d = 1'b1;
                    ovf_d = 1'b0;
                end else begin
                    bin_d = result_w;
                    err_d = 1'b0;
                    ovf_d = ovf_w;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.binaryNumber = bin_q;
    assign bus.enaOut       = ena_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.error        = err_q;
    assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed scenarios plus random
// BCD words checked against a decimal-arithmetic reference model.
module tb_bcd_to_binary_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bcd_to_binary_seq_if #(.binaryNumberWidth(32), .numberOfDigits(6)) ifa ();
    bcd_to_binary_seq_if #(.binaryNumberWidth(16), .numberOfDigits(6)) ifb ();

    bcd_to_binary_seq #(.binaryNumberWidth(32), .numberOfDigits(6)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    bcd_to_binary_seq #(.binaryNumberWidth(16), .numberOfDigits(6)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    // Reference: value = sum of digit * 10**position; any digit > 9 is invalid.
    function automatic void ref_conv(input logic [23:0] bcd, input int w,
                                     output logic [31:0] bin, output logic err,
                                     output logic ovf);
        longint unsigned val = 0;
        longint unsigned p   = 1;
        logic [23:0] tmp;
        logic [3:0]  d;
        err = 1'b0;
        tmp = bcd;
        for (int i = 0; i < 6; i++) begin
            d   = tmp[3:0];
            tmp = tmp >> 4;
            if (d > 4'd9) err = 1'b1;
            val = val + 64'(d) * p;
            p   = p * 10;
        end
        if (err) begin
            bin = '0;
            ovf = 1'b0;
        end else begin
            ovf = (val >= (64'd1 << w));
            bin = 32'(val % (64'd1 << w));
        end
    endfunction

    function automatic logic [23:0] rand_bcd(input bit allow_bad);
        logic [23:0] v = '0;
        for (int i = 0; i < 6; i++) begin
            if (allow_bad && ($urandom_range(0, 7) == 0))
                v = (v << 4) | 24'($urandom_range(10, 15));
            else
                v = (v << 4) | 24'($urandom_range(0, 9));
        end
        return v;
    endfunction

    task automatic start_a(input logic [23:0] bcd);
        ifa.BinaryDecimal = bcd;
        ifa.load = 1'b1;
        @(posedge clk); #1;
        ifa.load = 1'b0;
    endtask

    task automatic start_b(input logic [23:0] bcd);
        ifb.BinaryDecimal = bcd;
        ifb.load = 1'b1;
        @(posedge clk); #1;
        ifb.load = 1'b0;
    endtask

    // Waits (bounded) for enaOut; cycles counts edges since the load edge, 99 on timeout.
    task automatic wait_ena_a(output int cycles);
        cycles = 99;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (ifa.enaOut) begin
                cycles = c;
                return;
            end
        end
    endtask

    task automatic wait_ena_b(output int cycles);
        cycles = 99;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (ifb.enaOut) begin
                cycles = c;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifa.load = 1'b0; ifa.BinaryDecimal = '0;
        ifb.load = 1'b0; ifb.BinaryDecimal = '0;
        #2;
        checks++;
        if ({ifa.binaryNumber, ifa.enaOut, ifa.busy, ifa.error, ifa.overflow} !== 36'd0) begin
            errors++;
            $display("FAIL reset_a: got bin=%h ena=%b busy=%b err=%b ovf=%b, want all 0",
                     ifa.binaryNumber, ifa.enaOut, ifa.busy, ifa.error, ifa.overflow);
        end
        checks++;
        if ({ifb.binaryNumber, ifb.enaOut, ifb.busy, ifb.error, ifb.overflow} !== 20'd0) begin
            errors++;
            $display("FAIL reset_b: got bin=%h ena=%b busy=%b, want all 0",
                     ifb.binaryNumber, ifb.enaOut, ifb.busy);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int busy_cnt = 0;
        int at = 99;
        start_a(24'h123456);
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (ifa.busy) busy_cnt++;
            if (ifa.enaOut && at == 99) begin
                at = c;
                checks++;
                if (ifa.binaryNumber !== 32'h0001E240 || ifa.error !== 1'b0 || ifa.overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_value: got bin=%h err=%b ovf=%b, want 0001e240 0 0",
                             ifa.binaryNumber, ifa.error, ifa.overflow);
                end
            end
        end
        checks++;
        if (at !== 7) begin
            errors++;
            $display("FAIL basic_latency: enaOut %0d clocks after load, want 7", at);
        end
        checks++;
        if (busy_cnt !== 7) begin
            errors++;
            $display("FAIL basic_busy: busy high %0d cycles, want 7", busy_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int extra = 0;
        start_a(24'h000000);
        wait_ena_a(cyc);
        checks++;
        if (cyc !== 7 || ifa.binaryNumber !== 32'd0) begin
            errors++;
            $display("FAIL b2b_first: got latency=%0d bin=%h, want 7 0", cyc, ifa.binaryNumber);
        end
        start_a(24'h999999);
        wait_ena_a(cyc);
        checks++;
        if (cyc !== 7 || ifa.binaryNumber !== 32'h000F423F) begin
            errors++;
            $display("FAIL b2b_second: got latency=%0d bin=%h, want 7 000f423f", cyc, ifa.binaryNumber);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (ifa.enaOut) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL b2b_extra_ena: got %0d extra pulses, want 0", extra);
        end
    endtask

    task automatic test_invalid();
        int cyc;
        start_a(24'h12A456);
        wait_ena_a(cyc);
        checks++;
        if (cyc !== 7 || ifa.error !== 1'b1 || ifa.binaryNumber !== 32'd0 || ifa.overflow !== 1'b0) begin
            errors++;
            $display("FAIL invalid_digit: got lat=%0d err=%b bin=%h ovf=%b, want 7 1 0 0",
                     cyc, ifa.error, ifa.binaryNumber, ifa.overflow);
        end
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (ifa.error !== 1'b1) begin
            errors++;
            $display("FAIL invalid_hold: error=%b, want 1 held", ifa.error);
        end
        start_a(24'h000042);
        wait_ena_a(cyc);
        checks++;
        if (ifa.error !== 1'b0 || ifa.binaryNumber !== 32'd42) begin
            errors++;
            $display("FAIL invalid_recover: got err=%b bin=%0d, want 0 42", ifa.error, ifa.binaryNumber);
        end
    endtask

    task automatic test_load_during_busy();
        int pulses = 0;
        int at = 99;
        logic [31:0] val = '0;
        start_a(24'h123456);
        ifa.BinaryDecimal = 24'h999999;
        ifa.load = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (c == 3) ifa.load = 1'b0;
            if (ifa.enaOut) begin
                pulses++;
                at  = c;
                val = ifa.binaryNumber;
            end
        end
        checks++;
        if (pulses !== 1 || at !== 7 || val !== 32'h0001E240) begin
            errors++;
            $display("FAIL load_busy: got pulses=%0d at=%0d bin=%h, want 1 7 0001e240", pulses, at, val);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int cyc;
        start_a(24'h654321);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({ifa.binaryNumber, ifa.enaOut, ifa.busy, ifa.error, ifa.overflow} !== 36'd0) begin
            errors++;
            $display("FAIL reset_mid: got bin=%h ena=%b busy=%b err=%b ovf=%b, want all 0",
                     ifa.binaryNumber, ifa.enaOut, ifa.busy, ifa.error, ifa.overflow);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (ifa.enaOut) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_abort: got %0d enaOut pulses, want 0", pulses);
        end
        start_a(24'h000010);
        wait_ena_a(cyc);
        checks++;
        if (cyc !== 7 || ifa.binaryNumber !== 32'd10) begin
            errors++;
            $display("FAIL reset_restart: got lat=%0d bin=%0d, want 7 10", cyc, ifa.binaryNumber);
        end
    endtask

    task automatic test_width16();
        int cyc;
        start_b(24'h065535);
        wait_ena_b(cyc);
        checks++;
        if (cyc !== 7 || ifb.binaryNumber !== 16'hFFFF || ifb.overflow !== 1'b0 || ifb.error !== 1'b0) begin
            errors++;
            $display("FAIL w16_max: got lat=%0d bin=%h ovf=%b err=%b, want 7 ffff 0 0",
                     cyc, ifb.binaryNumber, ifb.overflow, ifb.error);
        end
        start_b(24'h065536);
        wait_ena_b(cyc);
        checks++;
        if (ifb.binaryNumber !== 16'h0000 || ifb.overflow !== 1'b1 || ifb.error !== 1'b0) begin
            errors++;
            $display("FAIL w16_overflow: got bin=%h ovf=%b err=%b, want 0000 1 0",
                     ifb.binaryNumber, ifb.overflow, ifb.error);
        end
    endtask

    task automatic test_random();
        int cyc;
        logic [23:0] bcd;
        logic [31:0] eb;
        logic        ee, eo;
        for (int n = 0; n < 25; n++) begin
            bcd = rand_bcd(1'b1);
            ref_conv(bcd, 32, eb, ee, eo);
            start_a(bcd);
            wait_ena_a(cyc);
            checks++;
            if (cyc !== 7 || ifa.binaryNumber !== eb || ifa.error !== ee || ifa.overflow !== eo) begin
                errors++;
                $display("FAIL rand_a %h: got lat=%0d bin=%h err=%b ovf=%b, want 7 %h %b %b",
                         bcd, cyc, ifa.binaryNumber, ifa.error, ifa.overflow, eb, ee, eo);
            end
        end
        for (int n = 0; n < 25; n++) begin
            bcd = rand_bcd(n[2:0] == 3'd0);
            ref_conv(bcd, 16, eb, ee, eo);
            start_b(bcd);
            wait_ena_b(cyc);
            checks++;
            if (cyc !== 7 || ifb.binaryNumber !== eb[15:0] || ifb.error !== ee || ifb.overflow !== eo) begin
                errors++;
                $display("FAIL rand_b %h: got lat=%0d bin=%h err=%b ovf=%b, want 7 %h %b %b",
                         bcd, cyc, ifb.binaryNumber, ifb.error, ifb.overflow, eb[15:0], ee, eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_invalid();
        test_load_during_busy();
        test_reset_mid();
        test_width16();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, want completion");
        $fatal(1, "timeout");
    end

endmodule
